bus_arbiter: RTL and testbench

Round-robin arbiter that shares the single-master SoC slave bus (valid/ready/error protocol, 32-bit address/data, 4-bit byte select) between NMASTERS requesters, e.g. the Algol core and a DMA/debug master. It sits between the masters and the address-decoding `mux_switch`. It grants one master at a time, holds the grant until the slave responds, and forwards the response only to the granted master. A built-in watchdog terminates hung transactions with an error.

---
 rtl/bus_arbiter_pkg.sv | 13 +
 rtl/bus_arbiter_rr_priority.sv | 33 +++
 rtl/bus_arbiter.sv | 117 +++++++++++
 tb/tb_bus_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the round-robin slave-bus arbiter: bus widths and FSM encoding.
package bus_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int SEL_W  = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/bus_arbiter_rr_priority.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping modulo NMASTERS.
module rr_priority
    import bus_arbiter_pkg::*;
#(
    parameter  int NMASTERS = 2,
    localparam int IDX_W    = $clog2(NMASTERS)
) (
    input  logic [NMASTERS-1:0] req,
    input  logic [IDX_W-1:0]    ptr,
    output logic [IDX_W-1:0]    winner,
    output logic                any_req
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NMASTERS - 1);

    logic [IDX_W-1:0] idx;
    logic             found;

    always_comb begin
        winner  = '0;
        any_req = |req;
        found   = 1'b0;
        idx     = ptr;
        for (int k = 0; k < NMASTERS; k++) begin
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
            idx = (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing the single-master slave bus between NMASTERS requesters,
// holding each grant until the slave (or the watchdog) completes the transaction.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int NMASTERS = 2,
    parameter int TIMEOUT  = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_W*NMASTERS-1:0] master_address,
    input  logic [DATA_W*NMASTERS-1:0] master_wdata,
    input  logic [SEL_W*NMASTERS-1:0]  master_wsel,
    input  logic [NMASTERS-1:0]        master_valid,
    output logic [DATA_W*NMASTERS-1:0] master_rdata,
    output logic [NMASTERS-1:0]        master_ready,
    output logic [NMASTERS-1:0]        master_error,
    output logic [ADDR_W-1:0]          slave_address,
    output logic [DATA_W-1:0]          slave_wdata,
    output logic [SEL_W-1:0]           slave_wsel,
    output logic                       slave_valid,
    input  logic [DATA_W-1:0]          slave_rdata,
    input  logic                       slave_ready,
    input  logic                       slave_error
);

    localparam int IDX_W = $clog2(NMASTERS);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NMASTERS - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [IDX_W-1:0] winner;
    logic             any_req;
    logic             busy;
    logic             gnt_valid;
    logic             live;
    logic             timeout_hit;
    logic             resp_rdy;
    logic             resp_err;

    rr_priority #(
        .NMASTERS(NMASTERS)
    ) u_rr_priority (
        .req    (master_valid),
        .ptr    (ptr_q),
        .winner (winner),
        .any_req(any_req)
    );

    assign busy        = (state_q == ST_BUSY);
    assign gnt_valid   = master_valid[grant_q];
    assign live        = busy && gnt_valid;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

    // Error beats ready, and a slave response beats a coincident timeout.
    assign resp_err = live && (slave_error || (timeout_hit && !slave_ready));
    assign resp_rdy = live && slave_ready && !slave_error;

    assign slave_valid   = live;
    assign slave_address = master_address[int'(grant_q)*ADDR_W +: ADDR_W];
    assign slave_wdata   = master_wdata[int'(grant_q)*DATA_W +: DATA_W];
    assign slave_wsel    = busy ? master_wsel[int'(grant_q)*SEL_W +: SEL_W] : '0;
    assign master_rdata  = {NMASTERS{slave_rdata}};

    always_comb begin
        master_ready          = '0;
        master_error          = '0;
        master_ready[grant_q] = resp_rdy;
        master_error[grant_q] = resp_err;
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (state_q == ST_IDLE) begin
            cnt_d = '0;
            if (any_req) begin
                grant_d = winner;
                state_d = ST_BUSY;
            end
        end else begin
            if (!gnt_valid) begin
                // Master abandoned its request: fall back without touching priority.
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else if (resp_rdy || resp_err) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                ptr_d   = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (2 masters, TIMEOUT=4) with hand-computed expectations.
module tb_bus_arbiter;

    localparam int N = 2;
    localparam logic [31:0] A0 = 32'h2001_0000;
    localparam logic [31:0] A1 = 32'h1000_0004;
    localparam logic [31:0] W0 = 32'h1234_5678;
    localparam logic [31:0] W1 = 32'hCAFE_0001;

    logic          clk;
    logic          rst;
    logic [63:0]   m_addr;
    logic [63:0]   m_wdata;
    logic [7:0]    m_wsel;
    logic [1:0]    m_valid;
    logic [63:0]   m_rdata;
    logic [1:0]    m_ready;
    logic [1:0]    m_error;
    logic [31:0]   s_addr;
    logic [31:0]   s_wdata;
    logic [3:0]    s_wsel;
    logic          s_valid;
    logic [31:0]   s_rdata;
    logic          s_ready;
    logic          s_error;

    int n_pass;
    int n_fail;
    int n_total;

    bus_arbiter #(
        .NMASTERS(N),
        .TIMEOUT (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .master_address(m_addr),
        .master_wdata  (m_wdata),
        .master_wsel   (m_wsel),
        .master_valid  (m_valid),
        .master_rdata  (m_rdata),
        .master_ready  (m_ready),
        .master_error  (m_error),
        .slave_address (s_addr),
        .slave_wdata   (s_wdata),
        .slave_wsel    (s_wsel),
        .slave_valid   (s_valid),
        .slave_rdata   (s_rdata),
        .slave_ready   (s_ready),
        .slave_error   (s_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_pass  = 0;
        n_fail  = 0;
        n_total = 0;
        rst     = 1'b1;
        m_addr  = {A1, A0};
        m_wdata = {W1, W0};
        m_wsel  = {4'h0, 4'h3};
        m_valid = 2'b11;
        s_rdata = 32'h0;
        s_ready = 1'b1;
        s_error = 1'b0;
        #2;
        chk("rst_slave_valid", 32'(s_valid), 32'h0);
        chk("rst_slave_wsel", 32'(s_wsel), 32'h0);
        chk("rst_master_ready", 32'(m_ready), 32'h0);
        chk("rst_master_error", 32'(m_error), 32'h0);
        chk("rst_slave_address", s_addr, A0);
        chk("rst_slave_wdata", s_wdata, W0);
        m_valid = 2'b00;
        s_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single master read: master 1, ready on 3rd BUSY cycle
        cyc();
        m_valid = 2'b10;
        #1 chk("read_idle_valid", 32'(s_valid), 32'h0);
        cyc();
        chk("read_busy1_valid", 32'(s_valid), 32'h1);
        chk("read_busy1_addr", s_addr, A1);
        chk("read_busy1_wsel", 32'(s_wsel), 32'h0);
        cyc();
        chk("read_busy2_ready", 32'(m_ready), 32'h0);
        cyc();
        s_ready = 1'b1;
        s_rdata = 32'hDEAD_BEEF;
        #1;
        chk("read_busy3_ready", 32'(m_ready), 32'h2);
        chk("read_busy3_error", 32'(m_error), 32'h0);
        chk("read_rdata_m1", m_rdata[63:32], 32'hDEAD_BEEF);
        chk("read_rdata_m0", m_rdata[31:0], 32'hDEAD_BEEF);
        cyc();
        m_valid = 2'b00;
        s_ready = 1'b0;
        #1 chk("read_bubble_valid", 32'(s_valid), 32'h0);

        // Abort: master 0 granted with pointer 0, then drops valid
        m_valid = 2'b01;
        cyc();
        chk("abort_busy_valid", 32'(s_valid), 32'h1);
        m_valid = 2'b00;
        s_ready = 1'b1;
        #1;
        chk("abort_no_valid", 32'(s_valid), 32'h0);
        chk("abort_no_ready", 32'(m_ready), 32'h0);
        cyc();
        s_ready = 1'b0;
        m_valid = 2'b11;
        #1 chk("abort_idle_valid", 32'(s_valid), 32'h0);

        // Re-grant of master 0 (pointer unchanged) doubling as write pass-through
        cyc();
        chk("regrant_addr", s_addr, A0);
        chk("write_wdata", s_wdata, W0);
        chk("write_wsel", 32'(s_wsel), 32'h3);
        chk("write_valid", 32'(s_valid), 32'h1);
        s_ready = 1'b1;
        #1 chk("write_ready", 32'(m_ready), 32'h1);
        cyc();
        s_ready = 1'b0;
        m_valid = 2'b10;
        #1;
        chk("write_bubble_wsel", 32'(s_wsel), 32'h0);
        chk("write_bubble_valid", 32'(s_valid), 32'h0);
        cyc();
        chk("next_grant_addr", s_addr, A1);
        chk("next_grant_valid", 32'(s_valid), 32'h1);

        // Asynchronous reset in the middle of BUSY
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(s_valid), 32'h0);
        chk("async_rst_ready", 32'(m_ready), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Contention with a 1-cycle slave: grants alternate 0,1,0,1
        m_valid = 2'b11;
        s_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("cont_addr", s_addr, (i % 2 == 0) ? A0 : A1);
            chk("cont_ready", 32'(m_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
            cyc();
            chk("cont_bubble", 32'(s_valid), 32'h0);
        end
        s_ready = 1'b0;
        m_valid = 2'b01;

        // Timeout: master 0, slave silent, error on 4th BUSY cycle
        for (int b = 1; b <= 3; b++) begin
            cyc();
            chk("to_wait_error", 32'(m_error), 32'h0);
        end
        cyc();
        chk("to_fire_error", 32'(m_error), 32'h1);
        chk("to_fire_ready", 32'(m_ready), 32'h0);
        m_valid = 2'b11;
        cyc();
        chk("to_idle_valid", 32'(s_valid), 32'h0);
        cyc();
        chk("to_ptr_adv_addr", s_addr, A1);

        // Race: ready lands on the would-be timeout cycle
        repeat (3) cyc();
        s_ready = 1'b1;
        #1;
        chk("race_ready", 32'(m_ready), 32'h2);
        chk("race_error", 32'(m_error), 32'h0);
        cyc();
        s_ready = 1'b0;

        // Ready and error together: error wins
        cyc();
        s_ready = 1'b1;
        s_error = 1'b1;
        #1;
        chk("both_error", 32'(m_error), 32'h1);
        chk("both_ready", 32'(m_ready), 32'h0);
        cyc();
        m_valid = 2'b00;
        s_ready = 1'b0;
        #1 chk("idle_ignores_error", 32'(m_error), 32'h0);
        s_error = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
